// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries, with a single-cycle flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Head reads as zero when empty so the outputs are defined straight out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity, keeping it a plain RAM.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, redirect target adder, one-outstanding imem request and the stale-response FSM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               br_valid,
  input  logic               br_cond,
  input  logic               br_zero,
  input  logic [ADDR_W-1:0]  br_base_pc,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_e        state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   target;
  logic                taken;
  logic                redirect;
  logic                complete;
  logic                push;
  logic                pop;
  logic                issue;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    occ_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENT_W-1:0]    head;

  assign taken    = br_valid && br_cond && br_zero;
  assign redirect = jmp_valid || taken;
  assign complete = imem_req && imem_ack;
  assign push     = complete && (state == FETCH) && !redirect;
  assign pop      = inst_valid && inst_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target = br_base_pc + ADDR_W'(INSTR_BYTES) + (br_offset << 2);
    if (jmp_valid) target = jmp_target;
  end

  // Occupancy after this edge; the outstanding request keeps its slot reserved.
  always_comb begin
    occ_next = count + CNT_W'(push) - CNT_W'(pop);
    if (redirect) occ_next = '0;
  end

  // A redirect edge never issues: the target goes through fetch_pc and is requested next edge.
  assign issue = (!imem_req || complete) && !redirect && (occ_next < CNT_W'(DEPTH));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      if (complete) imem_req <= 1'b0;
      // An unacked request keeps req/addr stable; its response must be dropped.
      state <= (imem_req && !imem_ack) ? DROP : FETCH;
    end else begin
      if (complete && state == DROP) state <= FETCH;
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fetch_pc;
        fetch_pc  <= fetch_pc + ADDR_W'(INSTR_BYTES);
      end else if (complete) begin
        imem_req <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_addr, imem_rdata}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head[ENT_W-1:INSTR_W];
  assign inst_data  = head[INSTR_W-1:0];

endmodule
